encoder_counter: RTL

- Consumes the one-cycle Increment/Decrement pulses and the button press/release pulses from the rotary-encoder front end.
- Turns them into a bounded user-setting value with the following features:
  - rotation acceleration;
  - saturate or wrap at the limits;
  - short-press and long-press classification;
  - long press restores the default value.
- Sits between the encoder decoder and application logic (display driver, PWM setpoint, menu).

---
 rtl/encoder_pkg.sv | 24 ++
 rtl/press_classifier.sv | 65 ++++++
 rtl/encoder_counter.sv | 121 ++++++++++++
 3 files changed

// File: rtl/encoder_pkg.sv
// Shared types and helpers for the rotary-encoder setting counter:
// button FSM states, detent direction and time-to-cycles conversion.
package encoder_pkg;

  typedef enum logic [1:0] {
    BTN_IDLE      = 2'd0,
    BTN_PRESSED   = 2'd1,
    BTN_LONG_HELD = 2'd2
  } btn_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_t;

  // units_per_sec is 1_000 for milliseconds and 1_000_000 for microseconds.
  function automatic int unsigned cycles_from_time(input int unsigned clock_hz,
                                                   input int unsigned units_per_sec,
                                                   input int unsigned amount);
    return clock_hz / units_per_sec * amount;
  endfunction

endpackage

// File: rtl/press_classifier.sv
// Button press FSM: classifies a press as short (released early) or long
// (held LONG_CYCLES), and flags the cycle in which the long threshold is hit.
module press_classifier
  import encoder_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 10_000_000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic press,
  input  logic release_btn,
  output logic short_press,
  output logic long_press,
  output logic reload
);

  localparam int CW = $clog2(LONG_CYCLES + 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYCLES - 1);

  btn_state_t      state;
  logic [CW-1:0]   hold_count;

  // A release in the threshold cycle still counts as a short press.
  always_comb begin
    reload = (state == BTN_PRESSED) && !release_btn && (hold_count == LONG_LAST);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state       <= BTN_IDLE;
      hold_count  <= '0;
      short_press <= 1'b0;
      long_press  <= 1'b0;
    end else begin
      short_press <= 1'b0;
      long_press  <= 1'b0;
      case (state)
        BTN_IDLE: begin
          if (press) begin
            state      <= BTN_PRESSED;
            hold_count <= '0;
          end
        end
        BTN_PRESSED: begin
          if (release_btn) begin
            short_press <= 1'b1;
            state       <= BTN_IDLE;
          end else if (reload) begin
            long_press <= 1'b1;
            state      <= BTN_LONG_HELD;
          end else begin
            hold_count <= hold_count + 1'b1;
          end
        end
        BTN_LONG_HELD: begin
          if (release_btn) state <= BTN_IDLE;
        end
        default: state <= BTN_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/encoder_counter.sv
// Bounded user-setting counter driven by encoder detents, with rotation
// acceleration, saturate/wrap limits and long-press restore of the default.
module encoder_counter
  import encoder_pkg::*;
#(
  parameter int unsigned CLOCK_HZ       = 10_000_000,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MIN_VALUE      = 0,
  parameter int unsigned MAX_VALUE      = 255,
  parameter int unsigned INIT_VALUE     = 0,
  parameter bit          WRAP           = 1'b0,
  parameter int unsigned FAST_STEP      = 10,
  parameter int unsigned FAST_WINDOW_US = 20_000,
  parameter int unsigned LONG_PRESS_MS  = 1000
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Increment_i,
  input  logic             Decrement_i,
  input  logic             ButtonPress_i,
  input  logic             ButtonRelease_i,
  output logic [WIDTH-1:0] Value_o,
  output logic             Changed_o,
  output logic             AtMin_o,
  output logic             AtMax_o,
  output logic             ShortPress_o,
  output logic             LongPress_o
);

  localparam int unsigned FAST_CYCLES = cycles_from_time(CLOCK_HZ, 1_000_000, FAST_WINDOW_US);
  localparam int unsigned LONG_CYCLES = cycles_from_time(CLOCK_HZ, 1_000, LONG_PRESS_MS);
  localparam int TW = $clog2(FAST_CYCLES + 2);
  localparam int XW = WIDTH + 2;

  typedef logic signed [XW-1:0] ext_t;

  // Two extra bits (carry plus sign) keep value +/- step free of overflow.
  localparam ext_t MIN_X  = ext_t'(MIN_VALUE);
  localparam ext_t MAX_X  = ext_t'(MAX_VALUE);
  localparam ext_t STEP_X = ext_t'(FAST_STEP);
  localparam logic [WIDTH-1:0] MIN_V  = WIDTH'(MIN_VALUE);
  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VALUE);
  localparam logic [TW-1:0]    TIMER_SAT = TW'(FAST_CYCLES);

  logic [TW-1:0]    timer;
  dir_t             last_dir;
  dir_t             dir_now;
  logic             reload;
  logic             detent;
  logic             fast;
  ext_t             cur;
  ext_t             step;
  ext_t             sum;
  ext_t             diff;
  logic [WIDTH-1:0] next_value;

  press_classifier #(
    .LONG_CYCLES (LONG_CYCLES)
  ) u_press (
    .Clock       (Clock),
    .Reset       (Reset),
    .press       (ButtonPress_i),
    .release_btn (ButtonRelease_i),
    .short_press (ShortPress_o),
    .long_press  (LongPress_o),
    .reload      (reload)
  );

  // NOTE: every variable written here gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    detent     = Increment_i ^ Decrement_i;
    dir_now    = Increment_i ? DIR_UP : DIR_DOWN;
    fast       = (last_dir == dir_now) && (timer < TIMER_SAT);
    cur        = $signed({2'b00, Value_o});
    step       = fast ? STEP_X : ext_t'(1);
    sum        = cur + step;
    diff       = cur - step;
    next_value = Value_o;
    if (reload) begin
      next_value = INIT_V;
    end else if (detent) begin
      if (Increment_i) begin
        if (WRAP && cur == MAX_X)  next_value = MIN_V;
        else if (sum > MAX_X)      next_value = MAX_V;
        else                       next_value = sum[WIDTH-1:0];
      end else begin
        if (WRAP && cur == MIN_X)  next_value = MAX_V;
        else if (diff < MIN_X)     next_value = MIN_V;
        else                       next_value = diff[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Value_o   <= INIT_V;
      Changed_o <= 1'b0;
      AtMin_o   <= (INIT_V == MIN_V);
      AtMax_o   <= (INIT_V == MAX_V);
      timer     <= TIMER_SAT;
      last_dir  <= DIR_NONE;
    end else begin
      Value_o   <= next_value;
      Changed_o <= (next_value != Value_o);
      AtMin_o   <= (next_value == MIN_V);
      AtMax_o   <= (next_value == MAX_V);
      // A reload drops any coincident detent and forces the next one slow.
      if (reload) begin
        timer <= TIMER_SAT;
      end else if (detent) begin
        timer    <= '0;
        last_dir <= dir_now;
      end else if (timer < TIMER_SAT) begin
        timer <= timer + 1'b1;
      end
    end
  end

endmodule
